// File: rtl/tensor_issue_pkg.sv
// ---------------------------------------------------------------------------
// tensor_issue_pkg
// Shared definitions for the tensor issue sequencer:
//   - tensor unit op codes (3-bit) and a legality helper
//   - BF16 lane width, lane count and packed vector width
//   - sequencer FSM state encoding
// ---------------------------------------------------------------------------
package tensor_issue_pkg;

    localparam int OP_W   = 3;
    localparam int BF16_W = 16;
    localparam int LANES  = 4;
    localparam int VEC_W  = BF16_W * LANES;

    typedef enum logic [OP_W-1:0] {
        OP_VADD = 3'd0,
        OP_VSUB = 3'd1,
        OP_VMUL = 3'd2,
        OP_FMAC = 3'd3,
        OP_RELU = 3'd4
    } tensor_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } seq_state_e;

    // Codes above RELU are reserved and answered with an error response.
    function automatic logic op_is_legal(input logic [OP_W-1:0] op);
        return (op <= OP_RELU);
    endfunction

endpackage

// File: rtl/tensor_issue_seq.sv
// ---------------------------------------------------------------------------
// tensor_issue_seq
// Accepts one command at a time, launches it on the 4-lane BF16 tensor unit,
// waits for the result and hands it back on a valid/ready response port.
// At most one operation is ever in flight.
//
// Parameters
//   TAG_W    width of the opaque command/response tag
//   TMO_CYC  WAIT cycles allowed before timeout (timeout build only)
//
// Ports
//   clk, rst                    rising-edge clock, synchronous active-high reset
//   cmd_valid/cmd_ready         command handshake
//   cmd_op, cmd_a/b/acc, cmd_tag command fields (4x BF16 packed, lane0 [15:0])
//   tu_start                    one-cycle launch pulse to the tensor unit
//   tu_op, tu_a/b/acc           operands, held from launch until done
//   tu_rd, tu_done              tensor unit result and its valid pulse
//   rsp_valid/rsp_ready         response handshake
//   rsp_data, rsp_tag, rsp_err  result, returned tag, error flag
//
// Build option
//   TENSOR_ISSUE_TIMEOUT_EN  when defined, WAIT gives up after TMO_CYC cycles
//                            without tu_done and answers with an error.
//                            Otherwise WAIT persists until tu_done.
//
// State | Meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for a command (only state with cmd_ready=1)
// ISSUE | single cycle, tu_start=1
// WAIT  | operation outstanding, waiting for tu_done (or timeout)
// RESP  | response presented, held until rsp_ready
// ---------------------------------------------------------------------------
module tensor_issue_seq
    import tensor_issue_pkg::*;
#(
    parameter int TAG_W   = 4,
    parameter int TMO_CYC = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [OP_W-1:0]  cmd_op,
    input  logic [VEC_W-1:0] cmd_a,
    input  logic [VEC_W-1:0] cmd_b,
    input  logic [VEC_W-1:0] cmd_acc,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic             tu_start,
    output logic [OP_W-1:0]  tu_op,
    output logic [VEC_W-1:0] tu_a,
    output logic [VEC_W-1:0] tu_b,
    output logic [VEC_W-1:0] tu_acc,
    input  logic [VEC_W-1:0] tu_rd,
    input  logic             tu_done,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [VEC_W-1:0] rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err
);

    if (TMO_CYC < 1) begin : g_tmo_cyc_check
        $error("tensor_issue_seq: TMO_CYC must be at least 1");
    end

    seq_state_e       state_q, state_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic [VEC_W-1:0] a_q, a_d;
    logic [VEC_W-1:0] b_q, b_d;
    logic [VEC_W-1:0] acc_q, acc_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [VEC_W-1:0] data_q, data_d;
    logic             err_q, err_d;
    logic             tmo_hit;

`ifdef TENSOR_ISSUE_TIMEOUT_EN
    localparam int CNT_W = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;

    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

    // Held at zero outside WAIT, so every WAIT visit starts from zero.
    always_comb begin
        tmo_cnt_d = '0;
        if (state_q == ST_WAIT) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    // Fires in the TMO_CYC-th WAIT cycle; tu_done in that cycle takes priority.
    assign tmo_hit = (state_q == ST_WAIT) && (tmo_cnt_q == CNT_W'(TMO_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        tag_d   = tag_q;
        data_d  = data_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    tag_d = cmd_tag;
                    if (op_is_legal(cmd_op)) begin
                        op_d    = cmd_op;
                        a_d     = cmd_a;
                        b_d     = cmd_b;
                        acc_d   = cmd_acc;
                        state_d = ST_ISSUE;
                    end else begin
                        data_d  = '0;
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (tu_done) begin
                    data_d  = tu_rd;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (tmo_hit) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            tag_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign tu_start  = (state_q == ST_ISSUE);
    assign rsp_valid = (state_q == ST_RESP);

    assign tu_op    = op_q;
    assign tu_a     = a_q;
    assign tu_b     = b_q;
    assign tu_acc   = acc_q;
    assign rsp_data = data_q;
    assign rsp_tag  = tag_q;
    assign rsp_err  = err_q;

endmodule

// File: doc/tensor_issue_seq.md
TENSOR_ISSUE_SEQ -- requirements
Module: tensor_issue_seq

Interface
REQ-001 SHALL have parameter TAG_W, default 4, width of command/response tag.
REQ-002 SHALL have parameter TMO_CYC, default 15, maximum cycles allowed in WAIT before timeout.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  sequencer accepts command this cycle.
REQ-007 cmd_op  input  3  op code (0 VADD, 1 VSUB, 2 VMUL, 3 FMAC, 4 RELU).
REQ-008 cmd_a, cmd_b, cmd_acc  input  64 each  packed 4x BF16 operands, lane0 in [15:0].
REQ-009 cmd_tag  input  TAG_W  opaque tag returned with response.
REQ-010 tu_start  output  1  one-cycle launch pulse to 4-lane tensor unit.
REQ-011 tu_op  output  3; tu_a, tu_b, tu_acc  output  64 each  operands to tensor unit, held stable from tu_start until tu_done.
REQ-012 tu_rd  input  64  tensor unit result; tu_done  input  1  one-cycle result-valid pulse.
REQ-013 rsp_valid  output  1; rsp_ready  input  1  response handshake.
REQ-014 rsp_data  output  64; rsp_tag  output  TAG_W; rsp_err  output  1  result, tag, error flag.

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-016 cmd_ready SHALL be 1 only in IDLE; transfer occurs when cmd_valid & cmd_ready.
REQ-017 On transfer with legal op (0..4): capture op/operands/tag into holding registers, go to ISSUE.
REQ-018 On transfer with illegal op (5..7): no tu_start; rsp_data=0, rsp_err=1, go directly to RESP.
REQ-019 ISSUE SHALL last exactly one cycle, asserting tu_start=1, then go to WAIT.
REQ-020 tu_op/tu_a/tu_b/tu_acc SHALL be driven from holding registers at all times (stable through ISSUE and WAIT).
REQ-021 In WAIT, tu_done=1 SHALL capture tu_rd into rsp_data, rsp_err=0, go to RESP next cycle.
REQ-022 tu_done in IDLE, ISSUE or RESP SHALL be ignored (no state or data change).
REQ-023 rsp_valid SHALL be 1 exactly in RESP; rsp_data/tag/err stable while rsp_valid=1 and rsp_ready=0.
REQ-024 RESP with rsp_ready=1 SHALL return to IDLE next cycle; no new command accepted in that same cycle.
REQ-025 Minimum command-to-response: transfer cycle N, tu_start N+1, rsp_valid one cycle after tu_done.
REQ-026 tu_start SHALL never assert while an operation is outstanding (at most one in flight).

Reset
REQ-027 While rst=1 at a clock edge: state=IDLE, cmd_ready=1 after reset release, tu_start=0, rsp_valid=0, rsp_err=0, rsp_data=0, rsp_tag=0, holding registers=0, timeout counter=0.
REQ-028 Reset mid-operation SHALL abandon the operation; a tu_done arriving afterwards SHALL be ignored per REQ-022.

Configuration
REQ-029 Macro TENSOR_ISSUE_TIMEOUT_EN defined: counter clears on entering WAIT, increments each WAIT cycle; if TMO_CYC cycles elapse without tu_done, go to RESP with rsp_data=0, rsp_err=1; tu_done in the same cycle as expiry wins (normal result).
REQ-030 Macro undefined: no counter; WAIT persists indefinitely until tu_done.

Structure
REQ-031 Op codes (3-bit), BF16 lane width (16), lane count (4) and FSM state encoding SHALL live in the shared tensor package.
REQ-032 Sequencer SHALL be a single module with no sub-modules; datapath is registers and muxes only.

Verification
REQ-033 VADD: a=0x3F80 per lane (1.0), b=0x4000 (2.0), tag=3; stub done after 3 cycles with rd=0x4040 x4 -> rsp_data=0x4040404040404040, tag=3, err=0.
REQ-034 Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid held, data/tag stable, cmd_ready=0 throughout, single tu_start total.
REQ-035 Illegal op=6 -> no tu_start, rsp_valid next cycle with err=1, data=0.
REQ-036 With TENSOR_ISSUE_TIMEOUT_EN, TMO_CYC=15, stub never returns done -> rsp_err=1 exactly 15 cycles into WAIT; done on cycle 15 -> err=0.
REQ-037 Spurious tu_done in IDLE, and rst asserted in WAIT followed by late tu_done -> no rsp_valid, state IDLE, cmd_ready=1.
REQ-038 Back-to-back FMAC commands tags 1,2 with stub latency 5 -> responses in order, tu_start pulses separated by >= 8 cycles.
